// File: rtl/sdram_rom_reader.sv
module sdram_rom_reader #(
  parameter int unsigned   AW      = 23,
  parameter logic [AW-1:0] BASE    = '0,
  parameter int unsigned   TIMEOUT = 255
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          port_req,
  input  logic          port_ack,
  output logic [AW-1:0] port_a,
  output logic [1:0]    port_ds,
  output logic          port_we,
  input  logic [15:0]   port_q,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t        state;
  logic [15:0]   word;
  logic [AW-1:0] tag;
  logic          valid;
  logic          lane;
  logic          upload_q;
  logic [15:0]   cnt;
  logic          ack_match;
  logic [AW-1:0] rd_word;
  logic          unused_addr;

  assign ack_match   = (port_ack == port_req);
  assign rd_word     = ioctl_addr[AW:1];
  assign unused_addr = ^ioctl_addr;
  assign port_ds     = 2'b11;
  assign port_we     = 1'b0;

  // port_req is deliberately outside the reset branch so a pending toggle
  // survives reset; DRAIN absorbs the matching ack.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= (port_req != port_ack) ? DRAIN : IDLE;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      port_a     <= '0;
      err        <= 1'b0;
      valid      <= 1'b0;
      word       <= '0;
      tag        <= '0;
      lane       <= 1'b0;
      cnt        <= '0;
      upload_q   <= 1'b0;
    end else begin
      upload_q <= ioctl_upload;

      if (ioctl_rd && ioctl_upload && state != IDLE)
        err <= 1'b1;

      case (state)
        IDLE: begin
          if (ioctl_rd && ioctl_upload) begin
            if (valid && tag == rd_word) begin
              ioctl_din <= ioctl_addr[0] ? word[15:8] : word[7:0];
            end else begin
              lane       <= ioctl_addr[0];
              port_a     <= rd_word + BASE;
              ioctl_wait <= 1'b1;
              state      <= REQ;
            end
          end
        end
        REQ: begin
          port_req <= ~port_req;
          cnt      <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (ack_match) begin
            word       <= port_q;
            tag        <= port_a - BASE;
            valid      <= 1'b1;
            ioctl_din  <= lane ? port_q[15:8] : port_q[7:0];
            ioctl_wait <= 1'b0;
            state      <= IDLE;
          end else if (cnt == TO_LAST) begin
            ioctl_din  <= 8'hFF;
            err        <= 1'b1;
            ioctl_wait <= 1'b0;
            cnt        <= '0;
            state      <= DRAIN;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DRAIN: begin
          if (ack_match || cnt == TO_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (upload_q && !ioctl_upload)
        valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdram_rom_reader.sv
module tb_sdram_rom_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset  = 1'b1;
  logic        upload = 1'b0;
  logic        rd     = 1'b0;
  logic [24:0] addr   = '0;
  logic [7:0]  din;
  logic        wt;
  logic        port_req;
  logic        port_ack = 1'b0;
  logic [22:0] port_a;
  logic [1:0]  ds;
  logic        we;
  logic [15:0] port_q = '0;
  logic        err;

  logic        rd_b   = 1'b0;
  logic [24:0] addr_b = '0;
  logic [7:0]  din_b, din_w;
  logic        wt_b, wt_w, req_b, req_w, err_b, err_w;
  logic [22:0] a_b, a_w;
  logic [1:0]  unused_ds_b, unused_ds_w;
  logic        unused_we_b, unused_we_w;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int last_n;

  bit          resp_en    = 1'b0;
  int          resp_delay = 5;
  logic [15:0] resp_data  = '0;
  int          resp_cnt   = 0;
  logic        prev_req   = 1'b0;
  int          toggles    = 0;

  sdram_rom_reader #(.TIMEOUT(16)) u_dut (
    .clk_sys(clk), .reset(reset), .ioctl_upload(upload), .ioctl_rd(rd),
    .ioctl_addr(addr), .ioctl_din(din), .ioctl_wait(wt), .port_req(port_req),
    .port_ack(port_ack), .port_a(port_a), .port_ds(ds), .port_we(we),
    .port_q(port_q), .err(err)
  );

  sdram_rom_reader #(.BASE(23'h008000)) u_base (
    .clk_sys(clk), .reset(reset), .ioctl_upload(upload), .ioctl_rd(rd_b),
    .ioctl_addr(addr_b), .ioctl_din(din_b), .ioctl_wait(wt_b), .port_req(req_b),
    .port_ack(req_b), .port_a(a_b), .port_ds(unused_ds_b), .port_we(unused_we_b),
    .port_q(16'h1234), .err(err_b)
  );

  sdram_rom_reader #(.BASE(23'h7FFFFF)) u_wrap (
    .clk_sys(clk), .reset(reset), .ioctl_upload(upload), .ioctl_rd(rd_b),
    .ioctl_addr(addr_b), .ioctl_din(din_w), .ioctl_wait(wt_w), .port_req(req_w),
    .port_ack(req_w), .port_a(a_w), .port_ds(unused_ds_w), .port_we(unused_we_w),
    .port_q(16'h1234), .err(err_w)
  );

  // SDRAM responder: acks resp_delay cycles after seeing an outstanding request
  always @(posedge clk) begin
    if (resp_en && port_req != port_ack) begin
      if (resp_cnt >= resp_delay) begin
        port_ack <= port_req;
        port_q   <= resp_data;
        resp_cnt <= 0;
      end else begin
        resp_cnt <= resp_cnt + 1;
      end
    end else begin
      resp_cnt <= 0;
    end
  end

  always @(posedge clk) begin
    if (port_req != prev_req) toggles <= toggles + 1;
    prev_req <= port_req;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic run_rd(input logic [24:0] a, input logic [7:0] expd, input bit miss, input int poke);
    int t0;
    int n;
    t0 = toggles;
    @(negedge clk);
    addr = a;
    rd   = 1'b1;
    exp_q.push_back(expd);
    @(negedge clk);
    rd = 1'b0;
    chk("wait_on_rd", 32'(wt), 32'(miss));
    n = 0;
    while (wt && n < 200) begin
      @(negedge clk);
      n++;
      if (poke != 0 && n == poke) begin
        addr = 25'h000100;
        rd   = 1'b1;
      end else begin
        rd = 1'b0;
      end
    end
    rd = 1'b0;
    last_n = n;
    chk("wait_bound", 32'(n < 200), 32'd1);
    chk("din", 32'(din), 32'(exp_q.pop_front()));
    chk("req_toggles", 32'(toggles - t0), 32'(miss));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with port_req == port_ack
    repeat (3) @(negedge clk);
    chk("rst_wait", 32'(wt), 32'd0);
    chk("rst_din", 32'(din), 32'h00);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_req", 32'(port_req), 32'd0);
    chk("port_ds", 32'(ds), 32'h3);
    chk("port_we", 32'(we), 32'd0);
    reset = 1'b0;

    // rd without upload is ignored
    @(negedge clk);
    addr = 25'h000010;
    rd   = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    repeat (3) @(negedge clk);
    chk("noupl_wait", 32'(wt), 32'd0);
    chk("noupl_toggles", 32'(toggles), 32'd0);
    chk("noupl_din", 32'(din), 32'h00);

    // miss then hit
    upload     = 1'b1;
    resp_en    = 1'b1;
    resp_delay = 5;
    resp_data  = 16'hBEEF;
    @(negedge clk);
    run_rd(25'h000010, 8'hEF, 1'b1, 0);
    chk("miss_port_a", 32'(port_a), 32'h8);
    chk("miss_err", 32'(err), 32'd0);
    run_rd(25'h000011, 8'hBE, 1'b0, 0);

    // BASE offset and AW-bit wrap
    @(negedge clk);
    addr_b = 25'h000002;
    rd_b   = 1'b1;
    @(negedge clk);
    rd_b = 1'b0;
    chk("base_port_a", 32'(a_b), 32'h008001);
    repeat (4) @(negedge clk);
    addr_b = 25'h000004;
    rd_b   = 1'b1;
    @(negedge clk);
    rd_b = 1'b0;
    chk("wrap_port_a", 32'(a_w), 32'h000001);
    chk("base2_port_a", 32'(a_b), 32'h008002);
    repeat (4) @(negedge clk);
    chk("wrap_din", 32'(din_w), 32'h34);
    chk("base_din", 32'(din_b), 32'h34);
    chk("base_wait", 32'(wt_b), 32'd0);
    chk("wrap_wait", 32'(wt_w), 32'd0);
    chk("aux_err", 32'({err_b, err_w}), 32'd0);

    // timeout: REQ cycle plus 16 WAIT cycles of wait high after the first sample
    resp_en = 1'b0;
    run_rd(25'h000030, 8'hFF, 1'b1, 0);
    chk("timeout_cycles", 32'(last_n), 32'd17);
    chk("timeout_err", 32'(err), 32'd1);
    resp_en    = 1'b1;
    resp_delay = 0;
    repeat (4) @(negedge clk);
    chk("drain_aligned", 32'(port_req), 32'(port_ack));
    run_rd(25'h000011, 8'hBE, 1'b0, 0);
    resp_delay = 2;
    resp_data  = 16'h1357;
    run_rd(25'h000040, 8'h57, 1'b1, 0);
    chk("err_sticky", 32'(err), 32'd1);

    // falling upload invalidates the cache
    @(negedge clk);
    upload = 1'b0;
    @(negedge clk);
    upload = 1'b1;
    @(negedge clk);
    run_rd(25'h000041, 8'h13, 1'b1, 0);

    // reset while WAIT is outstanding
    resp_delay = 10;
    resp_data  = 16'h5555;
    @(negedge clk);
    addr = 25'h000020;
    rd   = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_wait", 32'(wt), 32'd0);
    chk("rst2_din", 32'(din), 32'h00);
    chk("rst2_err", 32'(err), 32'd0);
    repeat (20) @(negedge clk);
    chk("rst2_aligned", 32'(port_req), 32'(port_ack));
    resp_delay = 6;
    resp_data  = 16'hBEEF;
    run_rd(25'h000010, 8'hEF, 1'b1, 2);
    chk("overrun_err", 32'(err), 32'd1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
